// File: rtl/sid_pkg.sv
// Shared 6581 voice-path constants, VCA state encoding and the waveform format helper.
package sid_pkg;

  localparam int SID_WAVE_W = 12;
  localparam int SID_ENV_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } vca_state_t;

  // The oscillator emits offset binary; flipping the MSB gives two's complement.
  function automatic logic signed [SID_WAVE_W-1:0] offset_to_signed(input logic [SID_WAVE_W-1:0] w);
    return $signed({~w[SID_WAVE_W-1], w[SID_WAVE_W-2:0]});
  endfunction

endpackage

// File: rtl/vca_serial_mul.sv
// Signed x unsigned shift-add multiplier, one multiplier bit per clock, LSB first.
// Only the product bits from DROP_LSB upward are exported.
module vca_serial_mul #(
  parameter int A_W      = 12,
  parameter int B_W      = 8,
  parameter int DROP_LSB = 4,
  parameter int P_W      = A_W + B_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic signed [A_W-1:0]         a_i,
  input  logic        [B_W-1:0]         b_i,
  output logic                          done_o,
  output logic signed [P_W-1:DROP_LSB]  prod_o
);

  localparam int CNT_W = $clog2(B_W) + 1;

  logic signed [P_W-1:0] acc_q;
  logic signed [P_W-1:0] a_q;
  logic        [B_W-1:0] b_q;
  logic        [CNT_W-1:0] cnt_q;
  logic                  run_q;

  // The multiplicand walks left instead of using a variable shifter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      acc_q <= '0;
      a_q   <= {{(P_W-A_W){a_i[A_W-1]}}, a_i};
      b_q   <= b_i;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      if (b_q[0]) begin
        acc_q <= acc_q + a_q;
      end
      a_q   <= a_q <<< 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CNT_W'(B_W-1)) begin
        run_q <= 1'b0;
      end
    end
  end

  assign done_o = run_q && (cnt_q == CNT_W'(B_W-1));
  assign prod_o = acc_q[P_W-1:DROP_LSB];

endmodule

// File: rtl/voice_vca.sv
// Per-voice VCA: captures waveform and envelope on sample_stb, multiplies serially, emits a scaled sample.
// Define VCA_ROUND_EN for round-half-up with saturation instead of plain truncation.
module voice_vca
  import sid_pkg::*;
#(
  parameter int WAVE_W = SID_WAVE_W,
  parameter int ENV_W  = SID_ENV_W,
  parameter int OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_stb,
  input  logic [WAVE_W-1:0]       wave_in,
  input  logic [ENV_W-1:0]        env_in,
  input  logic                    mute,
  output logic signed [OUT_W-1:0] amp_out,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int PW    = WAVE_W + ENV_W;
  localparam int SHIFT = PW - OUT_W;
`ifdef VCA_ROUND_EN
  localparam int DROP  = SHIFT - 1;
`else
  localparam int DROP  = SHIFT;
`endif

  vca_state_t            state_q;
  logic signed [OUT_W-1:0] amp_q;
  logic signed [OUT_W-1:0] amp_d;
  logic                  valid_q;
  logic                  busy_q;
  logic                  overrun_q;
  logic                  mute_q;

  logic                  start;
  logic                  mulDone;
  logic signed [WAVE_W-1:0] waveS;
  logic signed [PW-1:DROP]  prodHi;

  assign waveS = offset_to_signed(wave_in);
  assign start = (state_q == IDLE) && sample_stb;

  vca_serial_mul #(
    .A_W      (WAVE_W),
    .B_W      (ENV_W),
    .DROP_LSB (DROP)
  ) uMul (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .a_i     (waveS),
    .b_i     (env_in),
    .done_o  (mulDone),
    .prod_o  (prodHi)
  );

`ifdef VCA_ROUND_EN
  // Adding half an LSB then shifting equals the truncated value plus the first dropped bit.
  logic signed [OUT_W:0] rounded;
  assign rounded = {prodHi[PW-1], prodHi[PW-1:SHIFT]} + (OUT_W+1)'(prodHi[DROP]);

  always_comb begin
    amp_d = rounded[OUT_W-1:0];
    if (rounded[OUT_W] != rounded[OUT_W-1]) begin
      amp_d = rounded[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
    if (mute_q) begin
      amp_d = '0;
    end
  end
`else
  always_comb begin
    amp_d = prodHi;
    if (mute_q) begin
      amp_d = '0;
    end
  end
`endif

  // Strobes that land outside IDLE are dropped and flagged; the running multiply is untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      amp_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      mute_q    <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sample_stb) begin
            mute_q  <= mute;
            busy_q  <= 1'b1;
            state_q <= MUL;
          end
        end
        MUL: begin
          overrun_q <= sample_stb;
          if (mulDone) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          overrun_q <= sample_stb;
          amp_q     <= amp_d;
          valid_q   <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign amp_out   = amp_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_voice_vca.sv
// Scoreboard bench for voice_vca: expected samples queued at the strobe, checked when out_valid fires.
module tb_voice_vca;

  logic               clk = 1'b0;
  logic               rst;
  logic               sampleStb;
  logic [11:0]        waveIn;
  logic [7:0]         envIn;
  logic               muteIn;
  logic signed [15:0] ampOut;
  logic               outValid;
  logic               busyOut;
  logic               overrunOut;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int amp;
    int cyc;
  } exp_t;
  exp_t sb[$];

  voice_vca dut (
    .clk        (clk),
    .rst        (rst),
    .sample_stb (sampleStb),
    .wave_in    (waveIn),
    .env_in     (envIn),
    .mute       (muteIn),
    .amp_out    (ampOut),
    .out_valid  (outValid),
    .busy       (busyOut),
    .overrun    (overrunOut)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Reference: offset-binary to signed, multiply, then truncate or round-and-saturate.
  function automatic int model(input int w, input int e, input bit m);
    int p;
    p = (w - 2048) * e;
    if (m) p = 0;
`ifdef VCA_ROUND_EN
    p = (p + 8) >>> 4;
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
`else
    p = p >>> 4;
`endif
    return p;
  endfunction

  task automatic pulseStrobe(input logic [11:0] w, input logic [7:0] e, input logic m);
    @(negedge clk);
    waveIn    = w;
    envIn     = e;
    muteIn    = m;
    sampleStb = 1'b1;
    @(negedge clk);
    sampleStb = 1'b0;
  endtask

  task automatic applyStimulus(input logic [11:0] w, input logic [7:0] e, input logic m);
    exp_t x;
    @(negedge clk);
    x.amp = model(int'(w), int'(e), m);
    x.cyc = cyc + 1;
    sb.push_back(x);
    waveIn    = w;
    envIn     = e;
    muteIn    = m;
    sampleStb = 1'b1;
    @(negedge clk);
    sampleStb = 1'b0;
  endtask

  task automatic waitDone();
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      checkOutput("timeout_pending", sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && outValid) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("amp_out", int'(ampOut), e.amp);
        checkOutput("latency", cyc - e.cyc, 9);
      end
    end
  end

  initial begin
    rst       = 1'b0;
    sampleStb = 1'b0;
    waveIn    = 12'h800;
    envIn     = 8'h00;
    muteIn    = 1'b0;
    #1;
    checkOutput("rst_amp", int'(ampOut), 0);
    checkOutput("rst_valid", int'(outValid), 0);
    checkOutput("rst_busy", int'(busyOut), 0);
    checkOutput("rst_overrun", int'(overrunOut), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    $display("[TB] full scale with busy window");
    applyStimulus(12'hFFF, 8'hFF, 1'b0);
    checkOutput("busy_first", int'(busyOut), 1);
    repeat (8) @(negedge clk);
    checkOutput("busy_last", int'(busyOut), 1);
    @(negedge clk);
    checkOutput("busy_cleared", int'(busyOut), 0);
    waitDone();

    $display("[TB] negative full scale, zero and small values");
    applyStimulus(12'h000, 8'hFF, 1'b0); waitDone();
    applyStimulus(12'h800, 8'hFF, 1'b0); waitDone();
    applyStimulus(12'hC00, 8'h01, 1'b0); waitDone();
    applyStimulus(12'h809, 8'h01, 1'b0); waitDone();
    applyStimulus(12'h7F7, 8'h01, 1'b0); waitDone();
    applyStimulus(12'h3A5, 8'hB6, 1'b0); waitDone();

    $display("[TB] operands held while multiplying");
    applyStimulus(12'hA00, 8'h5A, 1'b0);
    waveIn = 12'h123; envIn = 8'h0F; muteIn = 1'b1;
    waitDone();

    $display("[TB] mute and zero envelope");
    applyStimulus(12'hFFF, 8'hFF, 1'b1);
    waveIn = 12'h000; envIn = 8'h80; muteIn = 1'b0;
    waitDone();
    applyStimulus(12'hFFF, 8'h00, 1'b0); waitDone();

    $display("[TB] overrun in MUL and in DONE");
    applyStimulus(12'hC00, 8'h03, 1'b0);
    @(negedge clk);
    checkOutput("no_overrun_idle", int'(overrunOut), 0);
    pulseStrobe(12'h000, 8'hFF, 1'b0);
    checkOutput("overrun_mul", int'(overrunOut), 1);
    @(negedge clk);
    checkOutput("overrun_cleared", int'(overrunOut), 0);
    repeat (3) @(negedge clk);
    pulseStrobe(12'h000, 8'hFF, 1'b0);
    checkOutput("overrun_done", int'(overrunOut), 1);
    checkOutput("valid_with_overrun", int'(outValid), 1);
    waitDone();
    repeat (12) @(negedge clk);

    $display("[TB] reset mid-multiply");
    applyStimulus(12'hFFF, 8'hFF, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_amp", int'(ampOut), 0);
    checkOutput("midrst_valid", int'(outValid), 0);
    checkOutput("midrst_busy", int'(busyOut), 0);
    checkOutput("midrst_overrun", int'(overrunOut), 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    applyStimulus(12'h400, 8'h40, 1'b0);
    waitDone();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
